// File: rtl/agc_requant.sv
// Requantizer with closed-loop gain control: arithmetic right shift, saturate to OUT_WIDTH,
// and step the shift each window of 2^PERIOD_2N outputs according to the clip count.
module agc_requant #(
    parameter int IN_WIDTH  = 16,
    parameter int OUT_WIDTH = 4,
    parameter int PERIOD_2N = 10,
    parameter int SHIFT_W   = 4
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 we,
    input  logic [IN_WIDTH-1:0]  in,
    input  logic                 agc_en,
    input  logic [SHIFT_W-1:0]   shift_man,
    input  logic [15:0]          thr_hi,
    input  logic [15:0]          thr_lo,
    output logic [OUT_WIDTH-1:0] out,
    output logic                 out_we,
    output logic                 sat,
    output logic [SHIFT_W-1:0]   shift,
    output logic [15:0]          ovfl_cnt,
    output logic                 upd
);

    localparam int                          MAX_SHIFT = IN_WIDTH - OUT_WIDTH;
    localparam logic [SHIFT_W-1:0]          MAX_SH    = SHIFT_W'(MAX_SHIFT);
    localparam logic signed [IN_WIDTH-1:0]  SAT_HI    = IN_WIDTH'(2 ** (OUT_WIDTH - 1) - 1);
    localparam logic signed [IN_WIDTH-1:0]  SAT_LO    = IN_WIDTH'(-(2 ** (OUT_WIDTH - 1)));

    logic                        r_v1;
    logic signed [IN_WIDTH-1:0]  r_s1;
    logic                        r_out_we;
    logic [OUT_WIDTH-1:0]        r_out;
    logic                        r_sat;
    logic [SHIFT_W-1:0]          r_shift;
    logic [PERIOD_2N-1:0]        r_cnt;
    logic [15:0]                 r_acc;
    logic [15:0]                 r_ovfl;
    logic                        r_upd;

    logic                        w_hi;
    logic                        w_lo;
    logic [OUT_WIDTH-1:0]        w_q;
    logic                        w_close;
    logic [15:0]                 w_total;
    logic [SHIFT_W-1:0]          w_man;

    // Stage 1: floor shift using the shift value live at the capture edge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_v1 <= 1'b0;
            r_s1 <= '0;
        end else begin
            r_v1 <= we;
            if (we) r_s1 <= $signed(in) >>> r_shift;
        end
    end

    assign w_hi = (r_s1 > SAT_HI);
    assign w_lo = (r_s1 < SAT_LO);
    assign w_q  = w_hi ? SAT_HI[OUT_WIDTH-1:0] :
                  w_lo ? SAT_LO[OUT_WIDTH-1:0] : r_s1[OUT_WIDTH-1:0];

    // Stage 2: clip to the output range; sat is forced low on idle cycles.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_out_we <= 1'b0;
            r_out    <= '0;
            r_sat    <= 1'b0;
        end else begin
            r_out_we <= r_v1;
            r_sat    <= r_v1 & (w_hi | w_lo);
            if (r_v1) r_out <= w_q;
        end
    end

    assign w_close = r_out_we & (&r_cnt);
    assign w_total = (r_acc == 16'hFFFF) ? r_acc : r_acc + {15'd0, r_sat};
    assign w_man   = (shift_man > MAX_SH) ? MAX_SH : shift_man;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cnt   <= '0;
            r_acc   <= '0;
            r_ovfl  <= '0;
            r_upd   <= 1'b0;
            r_shift <= MAX_SH;
        end else begin
            r_upd <= 1'b0;
            if (r_out_we) begin
                if (w_close) begin
                    r_ovfl <= w_total;
                    r_acc  <= '0;
                    r_cnt  <= '0;
                    r_upd  <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + PERIOD_2N'(1);
                    r_acc <= w_total;
                end
            end
            // Increment is tested first so thr_hi wins when both thresholds trip.
            if (!agc_en) begin
                r_shift <= w_man;
            end else if (w_close) begin
                if (w_total > thr_hi && r_shift < MAX_SH)
                    r_shift <= r_shift + SHIFT_W'(1);
                else if (w_total < thr_lo && r_shift != '0)
                    r_shift <= r_shift - SHIFT_W'(1);
            end
        end
    end

    assign out      = r_out;
    assign out_we   = r_out_we;
    assign sat      = r_sat;
    assign shift    = r_shift;
    assign ovfl_cnt = r_ovfl;
    assign upd      = r_upd;

endmodule

// File: tb/tb_agc_requant.sv
// Bench for agc_requant: a transaction-level reference model checked every cycle,
// plus directed literal expectations for latency, clipping, windowing and the gain loop.
module tb_agc_requant;

    localparam int IW = 16, OW = 4, P = 4, SW = 4;
    localparam int MAXS = IW - OW;
    localparam int WIN = 1 << P;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          we = 1'b0;
    logic [IW-1:0] din = '0;
    logic          agc_en = 1'b0;
    logic [SW-1:0] shift_man = 4'd12;
    logic [15:0]   thr_hi = '0;
    logic [15:0]   thr_lo = '0;
    logic [OW-1:0] out;
    logic          out_we, sat, upd;
    logic [SW-1:0] shift;
    logic [15:0]   ovfl_cnt;

    agc_requant #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .PERIOD_2N(P), .SHIFT_W(SW)) dut (
        .clk(clk), .resetn(resetn), .we(we), .in(din), .agc_en(agc_en),
        .shift_man(shift_man), .thr_hi(thr_hi), .thr_lo(thr_lo), .out(out),
        .out_we(out_we), .sat(sat), .shift(shift), .ovfl_cnt(ovfl_cnt), .upd(upd)
    );

    always #5 clk = ~clk;

    int n_pass = 0, n_total = 0;
    bit chk_en = 1'b0;

    task automatic check(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    endtask

    // Floor division by 2^s, then clip into the signed output range.
    function automatic void requant(input int v, input int s, output int q, output int c);
        int d;
        d = 1 << s;
        if (v >= 0) q = v / d;
        else        q = -((-v + d - 1) / d);
        c = 0;
        if (q > (1 << (OW - 1)) - 1) begin q = (1 << (OW - 1)) - 1; c = 1; end
        else if (q < -(1 << (OW - 1))) begin q = -(1 << (OW - 1)); c = 1; end
    endfunction

    // Reference model: each accepted sample becomes a result due one edge later;
    // the visible result is then tallied into the window on the following edge.
    typedef struct { int q; int s; int due; } ent_t;
    ent_t pend[$];
    int m_shift = MAXS, m_cnt = 0, m_acc = 0, m_ovfl = 0, m_upd = 0, ecount = 0;
    int v_vld = 0, v_out = 0, v_sat = 0;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pend.delete();
            m_shift = MAXS; m_cnt = 0; m_acc = 0; m_ovfl = 0; m_upd = 0;
            v_vld = 0; v_out = 0; v_sat = 0;
        end else begin
            int old_shift, total, q, c;
            ent_t e;
            ecount++;
            old_shift = m_shift;
            m_upd = 0;
            if (v_vld != 0) begin
                total = m_acc + v_sat;
                if (total > 65535) total = 65535;
                if (m_cnt == WIN - 1) begin
                    m_ovfl = total; m_acc = 0; m_cnt = 0; m_upd = 1;
                    if (agc_en) begin
                        if (total > int'(thr_hi) && m_shift < MAXS) m_shift = m_shift + 1;
                        else if (total < int'(thr_lo) && m_shift > 0) m_shift = m_shift - 1;
                    end
                end else begin
                    m_cnt = m_cnt + 1; m_acc = total;
                end
            end
            if (!agc_en) m_shift = (int'(shift_man) > MAXS) ? MAXS : int'(shift_man);
            v_vld = 0;
            if (pend.size() > 0 && pend[0].due == ecount) begin
                e = pend.pop_front();
                v_vld = 1; v_out = e.q; v_sat = e.s;
            end
            if (we) begin
                requant(int'($signed(din)), old_shift, q, c);
                e.q = q; e.s = c; e.due = ecount + 1;
                pend.push_back(e);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en && resetn) begin
            check("out_we", int'(out_we), v_vld);
            check("upd", int'(upd), m_upd);
            check("shift", int'(shift), m_shift);
            check("ovfl_cnt", int'(ovfl_cnt), m_ovfl);
            if (v_vld != 0) begin
                check("out", int'($signed(out)), v_out);
                check("sat", int'(sat), v_sat);
            end
        end
    end

    logic [IW-1:0] vals[$];

    task automatic send(input int v, input int eo, input int es, input string nm);
        @(negedge clk); we = 1'b1; din = IW'(v);
        @(negedge clk); we = 1'b0;
        check({nm, "_lat1"}, int'(out_we), 0);
        @(negedge clk);
        check({nm, "_we"}, int'(out_we), 1);
        check({nm, "_out"}, int'($signed(out)), eo);
        check({nm, "_sat"}, int'(sat), es);
    endtask

    task automatic drive_q(input int gapmax);
        foreach (vals[i]) begin
            @(negedge clk); we = 1'b1; din = vals[i];
            repeat ($urandom_range(0, gapmax)) begin @(negedge clk); we = 1'b0; end
        end
        @(negedge clk); we = 1'b0;
    endtask

    task automatic wait_upd(input string nm, input int lim);
        int got = 0;
        for (int c = 0; c < lim && got == 0; c++) begin
            @(negedge clk);
            if (upd) got = 1;
        end
        check({nm, "_upd_seen"}, got, 1);
    endtask

    task automatic do_reset();
        @(posedge clk); #2 resetn = 1'b0;
        @(negedge clk); resetn = 1'b1;
    endtask

    function automatic int sat_val();
        if ($urandom_range(0, 1) == 1) return int'($urandom_range(8, 30000));
        return -int'($urandom_range(9, 30000));
    endfunction

    initial begin
        int exp4[7] = '{11, 10, 9, 8, 7, 8, 7};
        int smask[WIN];
        int t, j;

        repeat (2) @(negedge clk);
        check("rst_out_we", int'(out_we), 0);
        check("rst_upd", int'(upd), 0);
        check("rst_ovfl", int'(ovfl_cnt), 0);
        check("rst_shift", int'(shift), MAXS);
        check("rst_sat", int'(sat), 0);
        resetn = 1'b1; chk_en = 1'b1;

        // Manual shift 12: full-scale inputs land exactly on the rails without clipping.
        send(32'h7FFF, 7, 0, "t1_pos");
        send(32'h8000, -8, 0, "t1_neg");

        shift_man = 4'd0;
        repeat (2) @(negedge clk);
        send(100, 7, 1, "t2_p100");
        send(-100, -8, 1, "t2_n100");
        send(5, 5, 0, "t2_p5");
        send(-3, -3, 0, "t2_n3");
        shift_man = 4'd15;
        repeat (2) @(negedge clk);
        check("t2_man_clip", int'(shift), 12);

        // Window of 16 gapped samples, exactly 5 clipping.
        shift_man = 4'd0;
        do_reset();
        repeat (2) @(negedge clk);
        for (int i = 0; i < WIN; i++) smask[i] = (i < 5) ? 1 : 0;
        for (int i = 0; i < WIN; i++) begin
            j = $urandom_range(0, WIN - 1);
            t = smask[i]; smask[i] = smask[j]; smask[j] = t;
        end
        vals.delete();
        for (int i = 0; i < WIN; i++)
            vals.push_back(IW'(smask[i] != 0 ? sat_val() : int'($urandom_range(0, 15)) - 8));
        fork
            drive_q(3);
            begin
                int nwe = 0, nupd = 0, last_we = -10;
                for (int c = 0; c < 200; c++) begin
                    @(negedge clk);
                    if (upd) begin
                        nupd++;
                        check("t3_we_before_upd", nwe, WIN);
                        check("t3_upd_timing", last_we, c - 1);
                        check("t3_ovfl", int'(ovfl_cnt), 5);
                    end
                    if (out_we) begin nwe++; last_we = c; end
                end
                check("t3_nupd", nupd, 1);
            end
        join
        vals.delete();
        for (int i = 0; i < WIN; i++) vals.push_back(IW'(int'($urandom_range(0, 15)) - 8));
        drive_q(2);
        wait_upd("t3_next", 10);
        check("t3_next_ovfl", int'(ovfl_cnt), 0);

        // Closed loop on a constant input, one clean burst per window.
        agc_en = 1'b1; thr_hi = 16'd3; thr_lo = 16'd1;
        do_reset();
        for (int k = 0; k < 7; k++) begin
            vals.delete();
            for (int i = 0; i < WIN; i++) vals.push_back(16'h0400);
            drive_q(0);
            wait_upd($sformatf("t4_w%0d", k), 10);
            check($sformatf("t4_shift%0d", k), int'(shift), exp4[k]);
        end

        // Reset mid-window with samples in flight.
        agc_en = 1'b0; shift_man = 4'd3;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk); we = 1'b1; din = IW'($urandom);
        end
        @(posedge clk); #2 resetn = 1'b0;
        #1;
        check("t5_out_we", int'(out_we), 0);
        check("t5_upd", int'(upd), 0);
        check("t5_ovfl", int'(ovfl_cnt), 0);
        check("t5_shift", int'(shift), MAXS);
        @(negedge clk); we = 1'b0; resetn = 1'b1;
        vals.delete();
        for (int i = 0; i < WIN - 1; i++) vals.push_back(IW'($urandom));
        drive_q(1);
        repeat (4) begin @(negedge clk); check("t5_no_early_upd", int'(upd), 0); end
        vals.delete(); vals.push_back(16'h1234);
        drive_q(0);
        wait_upd("t5_full", 10);

        // thr_hi=0 / thr_lo=max: both trip, increment must win each window.
        agc_en = 1'b0; shift_man = 4'd0;
        do_reset();
        repeat (2) @(negedge clk);
        check("t6_start", int'(shift), 0);
        agc_en = 1'b1; thr_hi = 16'h0000; thr_lo = 16'hFFFF;
        for (int k = 1; k <= MAXS; k++) begin
            vals.delete();
            for (int i = 0; i < WIN; i++) vals.push_back(16'h7FFF);
            drive_q(1);
            wait_upd($sformatf("t6_w%0d", k), 10);
            check($sformatf("t6_shift%0d", k), int'(shift), k);
        end

        // Random traffic; the per-cycle model comparison does the checking.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            we = ($urandom_range(0, 3) != 0);
            din = ($urandom_range(0, 1) == 1) ? IW'($urandom) : IW'(int'($urandom_range(0, 255)) - 128);
            if ((c % 150) == 0) begin
                agc_en = $urandom_range(0, 1) != 0;
                shift_man = SW'($urandom_range(0, 15));
                thr_hi = 16'($urandom_range(0, 16));
                thr_lo = 16'($urandom_range(0, 16));
            end
        end
        @(negedge clk); we = 1'b0;
        repeat (4) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
